data_mem_ctrl: RTL and testbench

Parametrised data memory for the MiniSys CPU, the successor of the plain word-only data RAM. It adds byte/halfword/word access with little-endian lane selection, sign/zero extension on loads, a configurable wait-state counter with a req/ack handshake, and registered read data. It sits between the CPU MEM stage and on-chip block RAM; the MEM stage stalls while `ready` is low.

---
 rtl/data_mem_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Byte/half/word data memory with sign/zero-extended loads, wait states and req/ack handshake.
// Optional misalignment detection enabled by defining DMEM_ALIGN_CHECK_EN.
module data_mem_ctrl #(
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned AL_W   = ADDR_W + 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic [AL_W-1:0]   addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              ack_q, ack_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       mem [DEPTH];

  logic              cur_we, cur_sign, bad, enter_resp, mem_we;
  logic [1:0]        cur_size;
  logic [AL_W-1:0]   cur_addr;
  logic [31:0]       cur_wdata, wword, rword, lane_data;
  logic [ADDR_W-1:0] idx;
  logic [3:0]        be;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^addr[31:AL_W];

  // Zero-wait accesses complete straight from IDLE, so they use the live inputs
  assign cur_we    = (state_q == S_IDLE) ? we            : we_q;
  assign cur_size  = (state_q == S_IDLE) ? size          : size_q;
  assign cur_sign  = (state_q == S_IDLE) ? sign          : sign_q;
  assign cur_addr  = (state_q == S_IDLE) ? addr[AL_W-1:0] : addr_q;
  assign cur_wdata = (state_q == S_IDLE) ? wdata         : wdata_q;
  assign idx       = cur_addr[AL_W-1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign bad = (cur_size == 2'b01) ? cur_addr[0] : (cur_size[1] & (|cur_addr[1:0]));
`else
  assign bad = 1'b0;
`endif

  // Lane enables and replicated store data
  always_comb begin
    be    = 4'b1111;
    wword = cur_wdata;
    case (cur_size)
      2'b00: begin
        be    = 4'b0001 << cur_addr[1:0];
        wword = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        be    = cur_addr[1] ? 4'b1100 : 4'b0011;
        wword = {2{cur_wdata[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  // Load lane extraction and extension
  always_comb begin
    rword     = mem[idx];
    byte_v    = 8'(rword >> {cur_addr[1:0], 3'b000});
    half_v    = cur_addr[1] ? rword[31:16] : rword[15:0];
    lane_data = rword;
    case (cur_size)
      2'b00:   lane_data = {{24{cur_sign & byte_v[7]}}, byte_v};
      2'b01:   lane_data = {{16{cur_sign & half_v[15]}}, half_v};
      default: lane_data = rword;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    size_d     = size_q;
    sign_d     = sign_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          size_d  = size;
          sign_d  = sign;
          addr_d  = addr[AL_W-1:0];
          wdata_d = wdata;
          if (WAIT_CYCLES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    ack_d   = (state_d == S_RESP);
    err_d   = 1'b0;
    rdata_d = rdata_q;
    mem_we  = enter_resp & cur_we & ~bad;
    if (enter_resp) begin
      err_d = bad;
      if (!cur_we) rdata_d = bad ? 32'h0 : lane_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b1;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory array is not reset; a reset edge drops any pending store
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  assign ready = ready_q;
  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: three instances (WAIT_CYCLES 0/1/2) sharing the input bus.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, req2;
  logic        we, sign;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        ready0, ready1, ready2, ack0, ack1, ack2, err0, err1, err2;
  logic [31:0] rdata0, rdata1, rdata2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_W(4),  .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we), .size(size), .sign(sign), .addr(addr),
    .wdata(wdata), .ready(ready0), .ack(ack0), .rdata(rdata0), .err(err0));
  data_mem_ctrl #(.ADDR_W(17), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .we(we), .size(size), .sign(sign), .addr(addr),
    .wdata(wdata), .ready(ready1), .ack(ack1), .rdata(rdata1), .err(err1));
  data_mem_ctrl #(.ADDR_W(17), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .req(req2), .we(we), .size(size), .sign(sign), .addr(addr),
    .wdata(wdata), .ready(ready2), .ack(ack2), .rdata(rdata2), .err(err2));

  function automatic logic f_ready(input int d);
    case (d) 0: return ready0; 1: return ready1; default: return ready2; endcase
  endfunction
  function automatic logic f_ack(input int d);
    case (d) 0: return ack0; 1: return ack1; default: return ack2; endcase
  endfunction
  function automatic logic f_err(input int d);
    case (d) 0: return err0; 1: return err1; default: return err2; endcase
  endfunction
  function automatic logic [31:0] f_rdata(input int d);
    case (d) 0: return rdata0; 1: return rdata1; default: return rdata2; endcase
  endfunction

  task automatic set_req(input int d, input logic v);
    case (d) 0: req0 = v; 1: req1 = v; default: req2 = v; endcase
  endtask

  // One access on instance d; lat = cycles from the acceptance cycle to the ack cycle
  task automatic do_access(input int d, input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!f_ready(d) && n < 20) begin
      @(negedge clk);
      n++;
    end
    we = w; size = sz; sign = sg; addr = a; wdata = wd;
    set_req(d, 1'b1);
    @(negedge clk);
    set_req(d, 1'b0);
    lat = 1;
    while (!f_ack(d) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = f_rdata(d);
    er = f_err(d);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic er;
    int lat;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
    we = 1'b0; size = 2'b10; sign = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready1); end
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack1); end
    checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata1); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err1); end
    rst = 1'b0;
    do_access(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    do_access(1, 1'b1, 2'b10, 1'b0, 32'h14, 32'h55, rd, er, lat);
    do_access(1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h55) begin errors++; $display("FAIL pre_reset_load: got %h expected 00000055", rd); end
    // Store accepted, then reset lands while it sits in WAIT
    @(negedge clk);
    we = 1'b1; size = 2'b10; addr = 32'h10; wdata = 32'hDEADBEEF; req1 = 1'b1;
    @(negedge clk);
    req1 = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL midwait_ready: got %b expected 1", ready1); end
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL midwait_ack: got %b expected 0", ack1); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL midwait_err: got %b expected 0", err1); end
    checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL midwait_rdata: got %h expected 0", rdata1); end
    @(negedge clk);
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL midwait_no_late_ack: got %b expected 0", ack1); end
    do_access(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL discarded_store: got %h expected 00000000", rd); end
  endtask

  task automatic test_word();
    logic [31:0] rd;
    logic er;
    int lat;
    do_access(2, 1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678, rd, er, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL store_latency: got %0d expected 3", lat); end
    do_access(2, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL load_latency: got %0d expected 3", lat); end
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL word_load: got %h expected 12345678", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL word_err: got %b expected 0", er); end
  endtask

  task automatic test_byte();
    logic [31:0] rd;
    logic er;
    int lat;
    do_access(1, 1'b1, 2'b10, 1'b0, 32'h80, 32'h11223344, rd, er, lat);
    do_access(1, 1'b1, 2'b00, 1'b0, 32'h82, 32'hFFFFFFAA, rd, er, lat);
    do_access(1, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h11AA3344) begin errors++; $display("FAIL byte_merge: got %h expected 11aa3344", rd); end
    do_access(1, 1'b1, 2'b00, 1'b0, 32'h8C, 32'h77, rd, er, lat);
    checks++; if (rd !== 32'h11AA3344) begin errors++; $display("FAIL store_holds_rdata: got %h expected 11aa3344", rd); end
    do_access(1, 1'b0, 2'b00, 1'b1, 32'h82, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFFFFAA) begin errors++; $display("FAIL lb: got %h expected ffffffaa", rd); end
    do_access(1, 1'b0, 2'b00, 1'b0, 32'h82, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h000000AA) begin errors++; $display("FAIL lbu: got %h expected 000000aa", rd); end
    do_access(1, 1'b0, 2'b00, 1'b1, 32'h83, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h00000011) begin errors++; $display("FAIL lb_positive: got %h expected 00000011", rd); end
  endtask

  task automatic test_half();
    logic [31:0] rd;
    logic er;
    int lat;
    do_access(1, 1'b1, 2'b10, 1'b0, 32'h84, 32'hA5A55A5A, rd, er, lat);
    do_access(1, 1'b1, 2'b01, 1'b0, 32'h86, 32'h12348001, rd, er, lat);
    do_access(1, 1'b0, 2'b01, 1'b1, 32'h86, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh: got %h expected ffff8001", rd); end
    do_access(1, 1'b0, 2'b01, 1'b0, 32'h86, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h00008001) begin errors++; $display("FAIL lhu: got %h expected 00008001", rd); end
    do_access(1, 1'b0, 2'b10, 1'b0, 32'h84, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h80015A5A) begin errors++; $display("FAIL half_merge: got %h expected 80015a5a", rd); end
    do_access(1, 1'b0, 2'b01, 1'b1, 32'h84, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h00005A5A) begin errors++; $display("FAIL lh_low: got %h expected 00005a5a", rd); end
    do_access(1, 1'b0, 2'b00, 1'b1, 32'h87, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_top: got %h expected ffffff80", rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd;
    logic er;
    int lat;
    logic        exp_err;
    logic [31:0] exp_word, exp_mis_load;
`ifdef DMEM_ALIGN_CHECK_EN
    exp_err = 1'b1; exp_word = 32'h01020304; exp_mis_load = 32'h0;
`else
    exp_err = 1'b0; exp_word = 32'hCAFEF00D; exp_mis_load = 32'hCAFEF00D;
`endif
    do_access(1, 1'b1, 2'b10, 1'b0, 32'h100, 32'h01020304, rd, er, lat);
    do_access(1, 1'b1, 2'b10, 1'b0, 32'h101, 32'hCAFEF00D, rd, er, lat);
    checks++; if (er !== exp_err) begin errors++; $display("FAIL mis_store_err: got %b expected %b", er, exp_err); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL mis_store_latency: got %0d expected 2", lat); end
    do_access(1, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, rd, er, lat);
    checks++; if (rd !== exp_word) begin errors++; $display("FAIL mis_store_word: got %h expected %h", rd, exp_word); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL aligned_err: got %b expected 0", er); end
    do_access(1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, rd, er, lat);
    checks++; if (rd !== exp_mis_load) begin errors++; $display("FAIL mis_load_data: got %h expected %h", rd, exp_mis_load); end
    checks++; if (er !== exp_err) begin errors++; $display("FAIL mis_load_err: got %b expected %b", er, exp_err); end
  endtask

  task automatic test_alias();
    logic [31:0] rd;
    logic er;
    int lat;
    do_access(0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0BADCAFE, rd, er, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL zero_wait_latency: got %0d expected 1", lat); end
    do_access(0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0BADCAFE) begin errors++; $display("FAIL alias_load: got %h expected 0badcafe", rd); end
  endtask

  task automatic test_back_to_back();
    int acks;
    logic exp_ack;
    acks = 0;
    @(negedge clk);
    we = 1'b0; size = 2'b10; sign = 1'b0; addr = 32'h0; req0 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_ack = (k % 2 == 1);
      if (ack0) acks++;
      checks++; if (ack0 !== exp_ack) begin errors++; $display("FAIL b2b_ack cycle %0d: got %b expected %b", k, ack0, exp_ack); end
      checks++; if (ready0 !== !exp_ack) begin errors++; $display("FAIL b2b_ready cycle %0d: got %b expected %b", k, ready0, !exp_ack); end
    end
    req0 = 1'b0;
    checks++; if (acks !== 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", acks); end
    checks++; if (rdata0 !== 32'h0BADCAFE) begin errors++; $display("FAIL b2b_rdata: got %h expected 0badcafe", rdata0); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misaligned();
    test_alias();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
